// File: rtl/sram_fifo_arb.sv
// sram_fifo_arb: two logical FIFOs sharing one ZBT SRAM. Keeps per-channel
// pointers/occupancy, arbitrates W0/R0/W1/R1 with burst-limited round-robin,
// issues one registered SRAM command per cycle and tags returning read data.

// Per-channel pointer and occupancy bookkeeping.
module sram_fifo_arb_chan #(
  parameter int PW = 18
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush_i,
  input  logic          wr_i,
  input  logic          rd_i,
  output logic [PW-1:0] wptr_o,
  output logic [PW-1:0] rptr_o,
  output logic [PW:0]   count_o
);
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;

  // Pointers wrap naturally at 2^PW; count moves by at most one per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_i) wptr_q <= wptr_q + PW'(1);
      if (rd_i) rptr_q <= rptr_q + PW'(1);
      if (wr_i && !rd_i)      cnt_q <= cnt_q + (PW+1)'(1);
      else if (rd_i && !wr_i) cnt_q <= cnt_q - (PW+1)'(1);
    end
  end

  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = cnt_q;
endmodule

module sram_fifo_arb #(
  parameter int WIDTH     = 18,
  parameter int RAM_DEPTH = 19,
  parameter int BURST     = 8,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [WIDTH-1:0]     wr_data0,
  input  logic [WIDTH-1:0]     wr_data1,
  input  logic                 wr_strobe0,
  input  logic                 wr_strobe1,
  output logic                 wr_ack0,
  output logic                 wr_ack1,
  input  logic                 rd_strobe0,
  input  logic                 rd_strobe1,
  output logic                 rd_ack0,
  output logic                 rd_ack1,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid0,
  output logic                 rd_valid1,
  input  logic                 flush0,
  input  logic                 flush1,
  output logic [RAM_DEPTH-1:0] capacity0,
  output logic [RAM_DEPTH-1:0] capacity1,
  output logic                 space_avail0,
  output logic                 space_avail1,
  output logic                 data_avail0,
  output logic                 data_avail1,
  output logic                 cmd_valid,
  output logic                 cmd_we,
  output logic [RAM_DEPTH-1:0] cmd_addr,
  output logic [WIDTH-1:0]     cmd_wdata,
  input  logic [WIDTH-1:0]     sram_rdata
);
  localparam int PW = RAM_DEPTH - 1;
  localparam logic [RAM_DEPTH-1:0] FULL = {1'b1, {PW{1'b0}}};

  // Requester index: bit1 = channel, bit0 = read.
  typedef enum logic [1:0] {W0 = 2'd0, R0 = 2'd1, W1 = 2'd2, R1 = 2'd3} req_e;

  logic [1:0][WIDTH-1:0]     wdat;
  logic [1:0]                wstb, rstb, flsh, wr_go, rd_go;
  logic [1:0][PW-1:0]        wptr, rptr;
  logic [1:0][RAM_DEPTH-1:0] cnt;
  logic [3:0]                req;

  assign wdat = {wr_data1, wr_data0};
  assign wstb = {wr_strobe1, wr_strobe0};
  assign rstb = {rd_strobe1, rd_strobe0};
  assign flsh = {flush1, flush0};

  for (genvar c = 0; c < 2; c++) begin : g_ch
    sram_fifo_arb_chan #(.PW(PW)) u_ch (
      .clk     (clk),
      .rstn    (rstn),
      .flush_i (flsh[c]),
      .wr_i    (wr_go[c]),
      .rd_i    (rd_go[c]),
      .wptr_o  (wptr[c]),
      .rptr_o  (rptr[c]),
      .count_o (cnt[c])
    );
    // Flush masks the channel's requests so it never acks in a flush cycle.
    assign req[2*c]   = wstb[c] & (cnt[c] != FULL) & ~flsh[c];
    assign req[2*c+1] = rstb[c] & (cnt[c] != '0)   & ~flsh[c];
  end

  req_e       cur_q, cur_d;
  logic [7:0] bcnt_q, bcnt_d;
  logic       gnt, found;
  logic [1:0] gidx, idx;

  // Burst-limited round-robin: stay on cur while under BURST, else scan
  // forward from cur+1 with cur itself checked last.
  always_comb begin
    gnt    = 1'b0;
    gidx   = cur_q;
    cur_d  = cur_q;
    bcnt_d = bcnt_q;
    found  = 1'b0;
    idx    = cur_q;
    if (req[cur_q] && (bcnt_q < 8'(BURST))) begin
      gnt    = 1'b1;
      bcnt_d = bcnt_q + 8'd1;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        idx = 2'(cur_q) + 2'(k);
        if (!found && req[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
      if (found) begin
        gnt    = 1'b1;
        cur_d  = req_e'(gidx);
        bcnt_d = 8'd1;
      end else begin
        bcnt_d = 8'd0;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_q  <= W0;
      bcnt_q <= '0;
    end else begin
      cur_q  <= cur_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign wr_go = {gnt & (gidx == 2'(W1)), gnt & (gidx == 2'(W0))};
  assign rd_go = {gnt & (gidx == 2'(R1)), gnt & (gidx == 2'(R0))};
  assign wr_ack0 = wr_go[0];
  assign wr_ack1 = wr_go[1];
  assign rd_ack0 = rd_go[0];
  assign rd_ack1 = rd_go[1];

  logic                 cmd_valid_q, cmd_we_q;
  logic [RAM_DEPTH-1:0] cmd_addr_q;
  logic [WIDTH-1:0]     cmd_wdata_q;

  // Command register: one cycle after the grant; fields hold when idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
    end else begin
      cmd_valid_q <= gnt;
      if (gnt) begin
        cmd_we_q   <= ~gidx[0];
        cmd_addr_q <= {gidx[1], (gidx[0] ? rptr[gidx[1]] : wptr[gidx[1]])};
        if (!gidx[0]) cmd_wdata_q <= wdat[gidx[1]];
      end
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_we    = cmd_we_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;

  // Read tag pipe: stage 0 aligns with the command, stage RD_LAT with
  // sram_rdata. Tags of a flushed channel are dropped as they shift.
  logic [RD_LAT:0] vld_pipe_q, ch_pipe_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      ch_pipe_q  <= '0;
    end else begin
      vld_pipe_q[0] <= gnt & gidx[0];
      ch_pipe_q[0]  <= gidx[1];
      for (int s = 1; s <= RD_LAT; s++) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1] & ~flsh[ch_pipe_q[s-1]];
        ch_pipe_q[s]  <= ch_pipe_q[s-1];
      end
    end
  end

  // The output stage is also masked combinationally so a flush in the
  // return cycle suppresses that word too.
  assign rd_valid0 = vld_pipe_q[RD_LAT] & ~ch_pipe_q[RD_LAT] & ~flush0;
  assign rd_valid1 = vld_pipe_q[RD_LAT] &  ch_pipe_q[RD_LAT] & ~flush1;
  assign rd_data   = sram_rdata;

  assign capacity0    = cnt[0];
  assign capacity1    = cnt[1];
  assign space_avail0 = (cnt[0] != FULL);
  assign space_avail1 = (cnt[1] != FULL);
  assign data_avail0  = (cnt[0] != '0);
  assign data_avail1  = (cnt[1] != '0);
endmodule

// File: tb/tb_sram_fifo_arb.sv
// Bench for sram_fifo_arb: directed phases plus a random phase, checked
// cycle by cycle against a queue-based FIFO/arbiter reference model, with a
// small SRAM model supplying read data RD_LAT cycles after each command.
module tb_sram_fifo_arb;
  localparam int W = 18, D = 4, B = 4, L = 2, N = 8;

  logic clk = 1'b0, rstn = 1'b0;
  logic [W-1:0] wr_data0, wr_data1, rd_data, cmd_wdata, sram_rdata;
  logic wr_strobe0, wr_strobe1, wr_ack0, wr_ack1, rd_strobe0, rd_strobe1;
  logic rd_ack0, rd_ack1, rd_valid0, rd_valid1, flush0, flush1;
  logic [D-1:0] capacity0, capacity1, cmd_addr;
  logic space_avail0, space_avail1, data_avail0, data_avail1, cmd_valid, cmd_we;

  sram_fifo_arb #(.WIDTH(W), .RAM_DEPTH(D), .BURST(B), .RD_LAT(L)) dut (
    .clk(clk), .rstn(rstn), .wr_data0(wr_data0), .wr_data1(wr_data1),
    .wr_strobe0(wr_strobe0), .wr_strobe1(wr_strobe1), .wr_ack0(wr_ack0),
    .wr_ack1(wr_ack1), .rd_strobe0(rd_strobe0), .rd_strobe1(rd_strobe1),
    .rd_ack0(rd_ack0), .rd_ack1(rd_ack1), .rd_data(rd_data),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .flush0(flush0),
    .flush1(flush1), .capacity0(capacity0), .capacity1(capacity1),
    .space_avail0(space_avail0), .space_avail1(space_avail1),
    .data_avail0(data_avail0), .data_avail1(data_avail1),
    .cmd_valid(cmd_valid), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .sram_rdata(sram_rdata));

  always #5 clk = ~clk;

  // SRAM model: writes land at the command edge; read data appears L cycles
  // after the command cycle.
  logic [W-1:0] mem [16];
  logic [W-1:0] rs0, rs1;
  always @(posedge clk) begin
    if (cmd_valid && cmd_we) mem[cmd_addr] <= cmd_wdata;
    rs0 <= mem[cmd_addr];
    rs1 <= rs0;
  end
  assign sram_rdata = rs1;

  // Reference model state.
  typedef struct { int due; int ch; logic [W-1:0] d; } rd_t;
  rd_t pend[$];
  logic [W-1:0] dq0[$], dq1[$];
  int m_cnt[2], m_wp[2], m_rp[2], m_cur, m_bcnt, cyc;
  logic e_cv, e_we;
  logic [D-1:0] e_addr;
  logic [W-1:0] e_wd;
  int chk = 0, errs = 0;
  bit seq0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0; end
    m_cur = 0; m_bcnt = 0;
    pend.delete(); dq0.delete(); dq1.delete();
    e_cv = 0; e_we = 0; e_addr = '0; e_wd = '0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check
  // the registered command. Called with inputs already driven at negedge.
  task automatic step();
    int g;
    logic [3:0] rq;
    logic [1:0] fl;
    bit hit;
    rd_t e;
    logic [W-1:0] d;
    #1;
    fl = {flush1, flush0};
    for (int i = pend.size() - 1; i >= 0; i--)
      if (fl[pend[i].ch]) pend.delete(i);
    rq[0] = wr_strobe0 && m_cnt[0] != N && !flush0;
    rq[1] = rd_strobe0 && m_cnt[0] != 0 && !flush0;
    rq[2] = wr_strobe1 && m_cnt[1] != N && !flush1;
    rq[3] = rd_strobe1 && m_cnt[1] != 0 && !flush1;
    g = -1;
    if (rq[m_cur] && m_bcnt < B) begin
      g = m_cur; m_bcnt++;
    end else begin
      for (int k = 1; k <= 4; k++)
        if (g < 0 && rq[(m_cur + k) % 4]) g = (m_cur + k) % 4;
      if (g >= 0) begin m_cur = g; m_bcnt = 1; end
      else m_bcnt = 0;
    end
    check("wr_ack0", 32'(wr_ack0), 32'(g == 0));
    check("rd_ack0", 32'(rd_ack0), 32'(g == 1));
    check("wr_ack1", 32'(wr_ack1), 32'(g == 2));
    check("rd_ack1", 32'(rd_ack1), 32'(g == 3));
    check("capacity0", 32'(capacity0), 32'(m_cnt[0]));
    check("capacity1", 32'(capacity1), 32'(m_cnt[1]));
    check("space_avail0", 32'(space_avail0), 32'(m_cnt[0] != N));
    check("space_avail1", 32'(space_avail1), 32'(m_cnt[1] != N));
    check("data_avail0", 32'(data_avail0), 32'(m_cnt[0] != 0));
    check("data_avail1", 32'(data_avail1), 32'(m_cnt[1] != 0));
    hit = 0;
    e = '{0, 0, '0};
    foreach (pend[i]) if (pend[i].due == cyc) begin hit = 1; e = pend[i]; end
    check("rd_valid0", 32'(rd_valid0), 32'(hit && e.ch == 0));
    check("rd_valid1", 32'(rd_valid1), 32'(hit && e.ch == 1));
    if (hit) check("rd_data", 32'(rd_data), 32'(e.d));
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].due == cyc) pend.delete(i);
    for (int i = 0; i < 2; i++)
      if (fl[i]) begin
        m_cnt[i] = 0; m_wp[i] = 0; m_rp[i] = 0;
        if (i == 0) dq0.delete(); else dq1.delete();
      end
    e_cv = (g >= 0);
    if (g == 0 || g == 2) begin
      d = (g == 0) ? wr_data0 : wr_data1;
      if (g == 0) dq0.push_back(d); else dq1.push_back(d);
      e_we = 1; e_addr = D'((g / 2) * N + m_wp[g / 2]); e_wd = d;
      m_wp[g / 2] = (m_wp[g / 2] + 1) % N; m_cnt[g / 2]++;
    end else if (g == 1 || g == 3) begin
      d = (g == 1) ? dq0.pop_front() : dq1.pop_front();
      pend.push_back('{cyc + L + 1, g / 2, d});
      e_we = 0; e_addr = D'((g / 2) * N + m_rp[g / 2]);
      m_rp[g / 2] = (m_rp[g / 2] + 1) % N; m_cnt[g / 2]--;
    end
    @(posedge clk);
    cyc++;
    #1;
    check("cmd_valid", 32'(cmd_valid), 32'(e_cv));
    check("cmd_we", 32'(cmd_we), 32'(e_we));
    check("cmd_addr", 32'(cmd_addr), 32'(e_addr));
    check("cmd_wdata", 32'(cmd_wdata), 32'(e_wd));
    if (g == 0) wr_data0 = seq0 ? wr_data0 + W'(1) : W'($urandom);
    if (g == 2) wr_data1 = W'($urandom);
    @(negedge clk);
  endtask

  task automatic set_in(input logic w0, input logic r0, input logic w1, input logic r1);
    wr_strobe0 = w0; rd_strobe0 = r0; wr_strobe1 = w1; rd_strobe1 = r1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst cmd_we", 32'(cmd_we), 32'd0);
    check("rst cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst cmd_wdata", 32'(cmd_wdata), 32'd0);
    check("rst capacity0", 32'(capacity0), 32'd0);
    check("rst capacity1", 32'(capacity1), 32'd0);
    check("rst space_avail0", 32'(space_avail0), 32'd1);
    check("rst data_avail0", 32'(data_avail0), 32'd0);
    check("rst rd_valid0", 32'(rd_valid0), 32'd0);
    check("rst rd_valid1", 32'(rd_valid1), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    set_in(0, 0, 0, 0);
    flush0 = 0; flush1 = 0;
    wr_data0 = W'('h100); wr_data1 = W'($urandom);
    cyc = 0;
    do_reset();

    // Five sequential writes on channel 0.
    seq0 = 1;
    set_in(1, 0, 0, 0);
    repeat (5) step();
    check("cap0 after 5 writes", 32'(capacity0), 32'd5);
    check("cap1 after 5 writes", 32'(capacity1), 32'd0);
    seq0 = 0;

    // Fill to N and hold the strobe against a full channel.
    repeat (5) step();
    check("space_avail0 full", 32'(space_avail0), 32'd0);

    // Read 3, write 3 (write pointer wraps), then drain all 8.
    set_in(0, 1, 0, 0); repeat (3) step();
    set_in(1, 0, 0, 0); repeat (3) step();
    set_in(0, 1, 0, 0); repeat (10) step();
    set_in(0, 0, 0, 0); repeat (4) step();
    check("data_avail0 drained", 32'(data_avail0), 32'd0);

    // Round-robin with all four requesters active.
    set_in(0, 0, 1, 0); repeat (4) step();
    set_in(1, 0, 0, 0); repeat (4) step();
    set_in(1, 1, 1, 1); repeat (16) step();
    set_in(0, 0, 0, 0); step();

    // Two reads on channel 0, one on channel 1, then flush channel 0.
    set_in(0, 1, 0, 0); repeat (2) step();
    set_in(0, 0, 0, 1); step();
    set_in(0, 0, 0, 0); flush0 = 1; step();
    flush0 = 0; repeat (5) step();
    check("cap0 after flush", 32'(capacity0), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
      flush0 = ($urandom % 50) == 0;
      flush1 = ($urandom % 50) == 0;
      step();
    end
    flush0 = 0; flush1 = 0;
    set_in(0, 0, 0, 0); repeat (5) step();

    // Asynchronous reset in the middle of a write burst.
    set_in(1, 0, 1, 0); repeat (3) step();
    #2 rstn = 1'b0;
    #1;
    check("async cmd_valid", 32'(cmd_valid), 32'd0);
    check("async capacity0", 32'(capacity0), 32'd0);
    check("async capacity1", 32'(capacity1), 32'd0);
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    set_in(1, 0, 1, 0); repeat (10) step();
    set_in(0, 1, 0, 1); repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end
endmodule

// File: doc/sram_fifo_arb.md
# sram_fifo_arb

Command scheduler that shares one external ZBT/NoBL SRAM between two independent logical FIFOs (channel 0 and channel 1). Each channel owns half of the SRAM address space. The block keeps the per-channel read/write pointers and occupancy, and arbitrates four requesters (W0, R0, W1, R1) with burst-limited round-robin. It issues one SRAM command per cycle to the pin-level SRAM driver and steers returning read data to the owning channel. It sits between the clock-crossing FIFOs and the SRAM driver, all in the ext_clk domain.

## Interface
- WIDTH, 18: SRAM data width.
- RAM_DEPTH, 19: SRAM address width. Each channel gets 2^(RAM_DEPTH-1) words.
- BURST, 8: maximum consecutive grants to one requester, 1..255.
- RD_LAT, 2: cycles from cmd_valid (read) to sram_rdata valid, 1..7.

Ports:
- clk  in  1  ext_clk domain clock.
- rstn  in  1  asynchronous, active-low reset.
- wr_data0 / wr_data1  in  WIDTH  write word, channel 0/1.
- wr_strobe0 / wr_strobe1  in  1  write word present (FWFT source not empty).
- wr_ack0 / wr_ack1  out  1  combinational; the word is consumed this cycle.
- rd_strobe0 / rd_strobe1  in  1  consumer can absorb RD_LAT+2 more words.
- rd_ack0 / rd_ack1  out  1  combinational; a read is issued this cycle.
- rd_data  out  WIDTH  pass-through of sram_rdata.
- rd_valid0 / rd_valid1  out  1  rd_data belongs to channel 0/1 this cycle.
- flush0 / flush1  in  1  synchronous channel clear.
- capacity0 / capacity1  out  RAM_DEPTH  words stored per channel.
- space_avail0 / space_avail1, data_avail0 / data_avail1  out  1  status flags.
- cmd_valid, cmd_we  out  1  registered SRAM command strobe and write select.
- cmd_addr  out  RAM_DEPTH  registered; {channel, pointer}.
- cmd_wdata  out  WIDTH  registered write data.
- sram_rdata  in  WIDTH  read data from the SRAM driver.

## Operation
- Per channel i, with N = 2^(RAM_DEPTH-1):
  - wptr_i and rptr_i are RAM_DEPTH-1 bits and wrap modulo N.
  - count_i is RAM_DEPTH bits, range 0..N.
  - space_avail_i = (count_i != N). data_avail_i = (count_i != 0). capacity_i = count_i.
- Requests:
  - reqW_i = wr_strobe_i & space_avail_i & ~flush_i.
  - reqR_i = rd_strobe_i & data_avail_i & ~flush_i.
- Rotation order is W0, R0, W1, R1, cyclic. State is cur (2 bits) and bcnt (8 bits).
- Grant rule, evaluated each cycle:
  - If req[cur] is set and bcnt < BURST: grant cur and increment bcnt.
  - Otherwise: grant the first requesting entry after cur in rotation order (wrapping, cur itself last). Set cur to that entry and bcnt to 1.
  - If nothing requests: no grant, cur holds, bcnt is cleared to 0.
- At most one grant per cycle.
  - A write and a read of the same channel are never simultaneous, so count changes by ±1 at most.
- Write grant on channel i:
  - wr_ack_i = 1.
  - Next cycle: cmd_valid=1, cmd_we=1, cmd_addr={i, wptr_i}, cmd_wdata=wr_data_i.
  - wptr_i and count_i each increment.
- Read grant on channel i:
  - rd_ack_i = 1.
  - Next cycle: cmd_valid=1, cmd_we=0, cmd_addr={i, rptr_i}.
  - rptr_i increments and count_i decrements.
  - The tag {valid, i} enters an RD_LAT-deep shift pipe.
- Read return:
  - rd_valid_i = pipe output valid and tag == i, in the cycle sram_rdata is valid.
  - rd_data is sram_rdata, unregistered.
- No grant: next cycle cmd_valid=0. cmd_we, cmd_addr and cmd_wdata hold their last values.
- Flush on channel i:
  - wptr_i, rptr_i and count_i clear to 0 at the next edge.
  - In-flight pipe tags for channel i are invalidated, so those words never produce rd_valid.
  - The other channel is unaffected.
  - Flush wins over a same-cycle request on that channel: no ack is given.
- Full boundary: at count_i == N, W_i is not requested. wr_ack_i stays low while wr_strobe_i is high.
- Empty boundary: at count_i == 0, R_i is not requested.

## Timing
- Ack-to-command latency: 1 cycle.
- Read ack to rd_valid: RD_LAT+1 cycles.
- Status flags and capacity are registered. They reflect an ack at the next edge.
- Sustained throughput is one command per cycle whenever any requester is active.
- A requester that holds its request continuously waits at most 3·BURST cycles for a grant.
- Reset values: all pointers and counts 0; cur=W0; bcnt=0; pipe cleared; cmd_valid=0, cmd_we=0, cmd_addr=0, cmd_wdata=0.
  - Combinational outputs after reset: rd_valid_i=0, data_avail_i=0, space_avail_i=1, capacity_i=0.
- Reset asserted mid-operation:
  - All state clears asynchronously.
  - In-flight reads are discarded and SRAM contents are ignored.
  - The first cycle after deassertion is a normal arbitration cycle.

## Test plan
- Write on one channel: after reset, wr_strobe0=1 for 5 words (0x100..0x104), reads idle.
  - Required: wr_ack0 high 5 cycles; cmd_addr 0x00000..0x00004 with cmd_we=1; capacity0=5; capacity1=0.
- Round-robin with bursts: BURST=4, all four requesters continuously active (counts nonzero, space available).
  - Required: grants in the repeating pattern W0×4, R0×4, W1×4, R1×4.
  - Channel 1 addresses have cmd_addr[RAM_DEPTH-1]=1.
- Read latency: RD_LAT=2, read of channel 1 acked at cycle T.
  - Required: cmd_valid at T+1; rd_valid1 at T+3 with rd_data=sram_rdata; rd_valid0 stays 0.
- Full and wrap: RAM_DEPTH=4 (N=8).
  - Write 8 words: space_avail0=0, and wr_ack0 stays low with strobe held.
  - Read 3, then write 3: wptr wraps, cmd_addr 0x0..0x2 are reused.
  - Read all 8 in order: count0 returns to 0 and data_avail0=0.
- Flush with reads in flight: issue 2 reads on channel 0 and 1 on channel 1, then assert flush0 the next cycle.
  - Required: no rd_valid0 for the flushed reads; rd_valid1 delivered; capacity0=0.
- Async reset mid-burst: drop rstn between clock edges during a write burst.
  - Required: cmd_valid falls immediately; capacities are 0; the first ack after release goes to the W0/R0/W1/R1 rotation starting from W0.
